// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: arctangent table, gain inverse and fixed-point shifts.
package cordic_pkg;
  localparam int W_DEF      = 16;
  localparam int STAGES_DEF = 16;
  localparam int GUARD_DEF  = 3;

  // Binary-angle arctangents of 2^-i, 16-bit full scale = 2*pi.
  localparam int          ATAN_N = 16;
  localparam logic [15:0] ATAN_TAB [ATAN_N] = '{
    16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0146, 16'h00A3, 16'h0051,
    16'h0029, 16'h0014, 16'h000A, 16'h0005, 16'h0003, 16'h0001, 16'h0001, 16'h0000};

  localparam logic [15:0] ANGLE_PI   = 16'h8000;
  localparam logic [15:0] K_INV      = 16'h26DD;
  localparam int          K_INV_FRAC = 14;

  // Q1.14 input -> Q3.15 internal -> Q3.12 output.
  localparam int PRE_SHIFT = 1;
  localparam int OUT_SHIFT = 3;

  function automatic logic [31:0] angle_scale(input logic [15:0] a, input int w);
    return {a, 16'h0000} >> (32 - w);
  endfunction

  function automatic logic [31:0] atan_w(input int i, input int w);
    if (i >= ATAN_N) return '0;
    return angle_scale(ATAN_TAB[i], w);
  endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring iteration: rotate by -+atan(2^-SHIFT) toward y = 0, registered and en-gated.
module cordic_vec_stage #(
  parameter int             IW       = 19,
  parameter int             W        = 16,
  parameter int             SHIFT    = 0,
  parameter logic [W-1:0]   ATAN_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic          zero_i,
  input  logic [IW-1:0] x_i,
  input  logic [IW-1:0] y_i,
  input  logic [W-1:0]  z_i,
  output logic          valid_o,
  output logic          zero_o,
  output logic [IW-1:0] x_o,
  output logic [IW-1:0] y_o,
  output logic [W-1:0]  z_o
);
  logic signed [IW-1:0] xs, ys, x_sh, y_sh, x_d, y_d, x_q, y_q;
  logic [W-1:0]         z_d, z_q;
  logic                 valid_q, zero_q;

  assign xs   = $signed(x_i);
  assign ys   = $signed(y_i);
  assign x_sh = xs >>> SHIFT;
  assign y_sh = ys >>> SHIFT;

  always_comb begin
    x_d = xs + y_sh;
    y_d = ys - x_sh;
    z_d = z_i + ATAN_VAL;
    if (ys[IW-1]) begin
      x_d = xs - y_sh;
      y_d = ys + x_sh;
      z_d = z_i - ATAN_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (en_i) begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      valid_q <= valid_i;
      zero_q  <= zero_i;
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;
  assign valid_o = valid_q;
  assign zero_o  = zero_q;
endmodule

// File: rtl/cordic_vectoring_pipe.sv
// Pipelined vectoring CORDIC: (X,Y) -> magnitude, residual y, binary-angle phase.
// Define CORDIC_GAIN_COMP_EN to add a K_INV multiply stage (latency 19 instead of 18).
module cordic_vectoring_pipe
  import cordic_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int GUARD  = GUARD_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] X_i,
  input  logic [W-1:0] Y_i,
  output logic         valid_O,
  output logic [W-1:0] X_O,
  output logic [W-1:0] Y_O,
  output logic [W-1:0] Z_O
);
  localparam int IW = W + GUARD;

  logic [STAGES:0][IW-1:0] x_pipe, y_pipe;
  logic [STAGES:0][W-1:0]  z_pipe;
  logic [STAGES:0]         vld_pipe, zero_pipe;

  // Pre-rotation folds the left half-plane onto the right so the iterations converge.
  logic signed [IW-1:0] x_ext, y_ext, x0_d, y0_d, x0_q, y0_q;
  logic [W-1:0]         z0_d, z0_q;
  logic                 vld0_q, zero0_q;

  assign x_ext = $signed({{GUARD{X_i[W-1]}}, X_i}) <<< PRE_SHIFT;
  assign y_ext = $signed({{GUARD{Y_i[W-1]}}, Y_i}) <<< PRE_SHIFT;

  always_comb begin
    x0_d = x_ext;
    y0_d = y_ext;
    z0_d = '0;
    if (x_ext[IW-1]) begin
      x0_d = -x_ext;
      y0_d = -y_ext;
      z0_d = W'(angle_scale(ANGLE_PI, W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q    <= '0;
      y0_q    <= '0;
      z0_q    <= '0;
      vld0_q  <= 1'b0;
      zero0_q <= 1'b0;
    end else if (en_i) begin
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      z0_q    <= z0_d;
      vld0_q  <= valid_i;
      zero0_q <= (X_i == '0) && (Y_i == '0);
    end
  end

  assign x_pipe[0]    = x0_q;
  assign y_pipe[0]    = y0_q;
  assign z_pipe[0]    = z0_q;
  assign vld_pipe[0]  = vld0_q;
  assign zero_pipe[0] = zero0_q;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_vec_stage #(
      .IW(IW), .W(W), .SHIFT(i), .ATAN_VAL(W'(atan_w(i, W)))
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en_i    (en_i),
      .valid_i (vld_pipe[i]),
      .zero_i  (zero_pipe[i]),
      .x_i     (x_pipe[i]),
      .y_i     (y_pipe[i]),
      .z_i     (z_pipe[i]),
      .valid_o (vld_pipe[i+1]),
      .zero_o  (zero_pipe[i+1]),
      .x_o     (x_pipe[i+1]),
      .y_o     (y_pipe[i+1]),
      .z_o     (z_pipe[i+1])
    );
  end

  logic [IW-1:0] xf, yf;
  logic [W-1:0]  zf;
  logic          vf, zerof;

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [IW+16:0] g_x, g_k, g_prod, g_rnd;
  logic [IW-1:0]         xg_q, yg_q;
  logic [W-1:0]          zg_q;
  logic                  vg_q, zerog_q;

  assign g_x    = (IW+17)'($signed(x_pipe[STAGES]));
  assign g_k    = (IW+17)'(K_INV);
  assign g_prod = g_x * g_k;
  assign g_rnd  = g_prod + (IW+17)'(1 << (K_INV_FRAC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      xg_q    <= '0;
      yg_q    <= '0;
      zg_q    <= '0;
      vg_q    <= 1'b0;
      zerog_q <= 1'b0;
    end else if (en_i) begin
      xg_q    <= IW'(g_rnd >>> K_INV_FRAC);
      yg_q    <= y_pipe[STAGES];
      zg_q    <= z_pipe[STAGES];
      vg_q    <= vld_pipe[STAGES];
      zerog_q <= zero_pipe[STAGES];
    end
  end

  assign xf    = xg_q;
  assign yf    = yg_q;
  assign zf    = zg_q;
  assign vf    = vg_q;
  assign zerof = zerog_q;
`else
  assign xf    = x_pipe[STAGES];
  assign yf    = y_pipe[STAGES];
  assign zf    = z_pipe[STAGES];
  assign vf    = vld_pipe[STAGES];
  assign zerof = zero_pipe[STAGES];
`endif

  // Round-half-up back to Q3.12; one extra bit keeps the +half from wrapping.
  logic signed [IW:0] x_rnd, y_rnd;
  logic [W-1:0]       x_q, y_q, z_q;
  logic               valid_q;

  assign x_rnd = (IW+1)'($signed(xf)) + (IW+1)'(1 << (OUT_SHIFT - 1));
  assign y_rnd = (IW+1)'($signed(yf)) + (IW+1)'(1 << (OUT_SHIFT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else if (en_i) begin
      valid_q <= vf;
      x_q     <= zerof ? '0 : W'(x_rnd >>> OUT_SHIFT);
      y_q     <= zerof ? '0 : W'(y_rnd >>> OUT_SHIFT);
      z_q     <= zerof ? '0 : zf;
    end
  end

  assign valid_O = valid_q;
  assign X_O     = x_q;
  assign Y_O     = y_q;
  assign Z_O     = z_q;
endmodule
